// File: rtl/platform_collision_scanner.sv
// Time-multiplexed doodle-vs-platform collision engine: scans one platform slot per clock,
// keeps the topmost qualifying landing platform and publishes ground/collision results with done.
module platform_collision_scanner #(
  parameter int N_PLAT  = 93,
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int EARTH   = 440,
  parameter int FOOT_LO = 80,
  parameter int FOOT_HI = 50,
  parameter int REACH_L = 61,
  parameter int REACH_R = 80,
  parameter int MOVE_Y  = 420,
  parameter int IDX_W   = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_PLAT*2*X_W-1:0] platforms,
  input  logic [N_PLAT-1:0]       platform_activation,
  input  logic [X_W-1:0]          doodle_x,
  input  logic [Y_W-1:0]          doodle_y,
  input  logic                    doodle_fall_direction,
  output logic                    busy,
  output logic                    done,
  output logic                    doodle_collision,
  output logic                    move_collision,
  output logic [2*Y_W-1:0]        ground,
  output logic [IDX_W-1:0]        hit_index
);

  localparam int C_W = X_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUBLISH} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [X_W-1:0]         dx_q;
  logic [Y_W-1:0]         dy_q;
  logic                   fall_q;
  logic                   best_vld_q;
  logic signed [X_W-1:0]  best_y_q;
  logic [Y_W-1:0]         best_x_q;
  logic [IDX_W-1:0]       best_idx_q;
  logic                   done_q, coll_q, move_q;
  logic [2*Y_W-1:0]       ground_q;
  logic [IDX_W-1:0]       hit_q;

  logic [2*X_W-1:0]       slot;
  logic signed [X_W-1:0]  py, px;
  logic signed [C_W-1:0]  py_e, px_e, dx_e, dy_e;
  logic                   hit_now, better, last;

  // Widen everything to X_W+2 signed so negative platform coordinates and window offsets never wrap.
  always_comb begin
    slot    = platforms[idx_q*2*X_W +: 2*X_W];
    py      = slot[2*X_W-1:X_W];
    px      = slot[X_W-1:0];
    py_e    = C_W'(py);
    px_e    = C_W'(px);
    dx_e    = signed'(C_W'(dx_q));
    dy_e    = signed'(C_W'(dy_q));
    hit_now = platform_activation[idx_q] && fall_q
              && (py_e - C_W'(FOOT_LO) <= dy_e) && (dy_e <= py_e - C_W'(FOOT_HI))
              && (px_e - C_W'(REACH_L) <= dx_e) && (dx_e <= px_e + C_W'(REACH_R));
    better  = hit_now && (!best_vld_q || (py < best_y_q));
    last    = (idx_q == IDX_W'(N_PLAT - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_SCAN;
      S_SCAN:    if (last)  state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      fall_q     <= 1'b0;
      best_vld_q <= 1'b0;
      best_y_q   <= '0;
      best_x_q   <= '0;
      best_idx_q <= '0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      move_q     <= 1'b0;
      ground_q   <= {Y_W'(EARTH), {Y_W{1'b0}}};
      hit_q      <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dx_q       <= doodle_x;
            dy_q       <= doodle_y;
            fall_q     <= doodle_fall_direction;
            idx_q      <= '0;
            best_vld_q <= 1'b0;
          end
        end
        S_SCAN: begin
          idx_q <= idx_q + 1'b1;
          if (better) begin
            best_vld_q <= 1'b1;
            best_y_q   <= py;
            best_x_q   <= px[Y_W-1:0];
            best_idx_q <= idx_q;
          end
        end
        S_PUBLISH: begin
          done_q <= 1'b1;
          if (best_vld_q) begin
            ground_q <= {best_y_q[Y_W-1:0], best_x_q};
            hit_q    <= best_idx_q;
            coll_q   <= 1'b1;
            move_q   <= (best_y_q[Y_W-1:0] < Y_W'(MOVE_Y));
          end else begin
            // Nothing hit: the doodle can still be resting on the floor.
            move_q <= 1'b0;
            coll_q <= (ground_q[2*Y_W-1:Y_W] == Y_W'(EARTH)) && (dy_q > Y_W'(EARTH - FOOT_LO));
          end
        end
        default: ;
      endcase
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign doodle_collision = coll_q;
  assign move_collision   = move_q;
  assign ground           = ground_q;
  assign hit_index        = hit_q;

endmodule

// File: tb/tb_platform_collision_scanner.sv
// Randomised and directed bench for platform_collision_scanner against a slot-array reference model.
module tb_platform_collision_scanner;
  localparam int N     = 93;
  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int IDX_W = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [N*2*X_W-1:0] platforms = '0;
  logic [N-1:0]       act_v = '0;
  logic [X_W-1:0]     dx = '0;
  logic [Y_W-1:0]     dy = '0;
  logic               fall = 1'b0;
  logic               busy, done, coll, move;
  logic [2*Y_W-1:0]   ground;
  logic [IDX_W-1:0]   hit_index;

  platform_collision_scanner #(.N_PLAT(N), .X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .rst(rst), .start(start), .platforms(platforms),
    .platform_activation(act_v), .doodle_x(dx), .doodle_y(dy),
    .doodle_fall_direction(fall), .busy(busy), .done(done),
    .doodle_collision(coll), .move_collision(move), .ground(ground),
    .hit_index(hit_index)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int py[N];
  int px[N];
  bit act[N];

  // reference model state
  int m_gy = 440, m_gx = 0, m_hit = 0, m_cnt = 0;
  bit m_coll = 0, m_move = 0, m_done = 0;
  int l_dx = 0, l_dy = 0;
  bit l_fall = 0;

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      platforms[i*2*X_W +: 2*X_W] = {X_W'(py[i]), X_W'(px[i])};
      act_v[i] = act[i];
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < N; i++) begin
      py[i] = 0; px[i] = 0; act[i] = 0;
    end
  endtask

  task automatic publish();
    int best;
    best = -1;
    for (int i = 0; i < N; i++) begin
      if (act[i] && l_fall && (py[i] - 80 <= l_dy) && (l_dy <= py[i] - 50)
          && (px[i] - 61 <= l_dx) && (l_dx <= px[i] + 80)) begin
        if (best < 0 || py[i] < py[best]) best = i;
      end
    end
    if (best >= 0) begin
      m_gy   = py[best] & 1023;
      m_gx   = px[best] & 1023;
      m_hit  = best;
      m_coll = 1;
      m_move = (m_gy < 420);
    end else begin
      m_move = 0;
      m_coll = (m_gy == 440) && (l_dy > 360);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_gy = 440; m_gx = 0; m_hit = 0; m_coll = 0; m_move = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          publish();
          m_done = 1;
        end
      end else if (start) begin
        l_dx = dx; l_dy = dy; l_fall = fall;
        m_cnt = N + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (m_cnt > 0) ? 1 : 0);
    chk("done", done, m_done);
    chk("ground_y", ground[2*Y_W-1:Y_W], m_gy);
    chk("ground_x", ground[Y_W-1:0], m_gx);
    chk("hit_index", hit_index, m_hit);
    chk("collision", coll, m_coll);
    chk("move", move, m_move);
  end

  task automatic scan(input int x, input int y, input bit f, input int pulse_at);
    int lat;
    @(negedge clk);
    dx = X_W'(x); dy = Y_W'(y); fall = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = (lat == pulse_at);
      if (start) dx = X_W'(x + 300);
    end while (!done && lat < N + 10);
    start = 1'b0;
    chk("latency", lat, N + 1);
  endtask

  task automatic set_slot(input int i, input int y, input int x);
    py[i] = y; px[i] = x; act[i] = 1;
  endtask

  initial begin
    int seen;
    int r;
    int dxs[4];
    int exps[4];
    clear_slots();
    apply();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // nothing active, doodle in the air
    scan(100, 300, 1, 0);
    chk("t1_coll", coll, 0);
    chk("t1_ground", ground, 440 * 1024);

    // single landing platform
    set_slot(5, 400, 200); apply();
    scan(210, 340, 1, 0);
    chk("t2_coll", coll, 1);
    chk("t2_ground", ground, 400 * 1024 + 200);
    chk("t2_hit", hit_index, 5);
    chk("t2_move", move, 1);

    // rising doodle never lands
    scan(210, 340, 0, 0);
    chk("t4_coll", coll, 0);
    chk("t4_ground_hold", ground, 400 * 1024 + 200);

    // lower y wins over lower index
    clear_slots(); set_slot(3, 370, 200); set_slot(7, 350, 200); apply();
    scan(210, 300, 1, 0);
    chk("t3_hit", hit_index, 7);
    chk("t3_ground", ground, 350 * 1024 + 200);

    // tie on y goes to lowest index
    clear_slots(); set_slot(9, 400, 200); set_slot(2, 400, 200); apply();
    scan(210, 340, 1, 0);
    chk("t3_tie_hit", hit_index, 2);

    // scroll threshold
    clear_slots(); set_slot(0, 420, 200); apply();
    scan(210, 360, 1, 0);
    chk("move_at_420", move, 0);
    clear_slots(); set_slot(0, 419, 200); apply();
    scan(210, 360, 1, 0);
    chk("move_at_419", move, 1);

    // horizontal and vertical window edges
    clear_slots(); set_slot(0, 400, 200); apply();
    dxs = '{139, 280, 138, 281}; exps = '{1, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      scan(dxs[k], 340, 1, 0);
      chk("t5_x_edge", coll, exps[k]);
    end
    dxs = '{320, 350, 319, 351};
    for (int k = 0; k < 4; k++) begin
      scan(210, dxs[k], 1, 0);
      chk("t5_y_edge", coll, exps[k]);
    end

    // negative platform x must not wrap
    clear_slots(); set_slot(0, 400, -20); apply();
    scan(0, 340, 1, 0);
    chk("neg_x_hit", coll, 1);
    chk("neg_x_ground", ground, 400 * 1024 + 1004);
    scan(61, 340, 1, 0);
    chk("neg_x_miss", coll, 0);

    // standing on the floor
    clear_slots(); apply();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    scan(100, 370, 0, 0);
    chk("floor_coll", coll, 1);
    scan(100, 360, 1, 0);
    chk("floor_edge", coll, 0);

    // start while busy is ignored
    set_slot(5, 400, 200); apply();
    scan(210, 340, 1, 20);
    chk("t6_hit", hit_index, 5);

    // reset mid-scan aborts
    @(negedge clk); dx = 210; dy = 340; fall = 1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_ground", ground, 440 * 1024);
    chk("rst_busy", busy, 0);
    seen = 0;
    repeat (N + 5) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    scan(210, 340, 1, 0);
    chk("clean_hit", hit_index, 5);
    chk("clean_coll", coll, 1);

    // randomised scans
    for (int s = 0; s < 25; s++) begin
      int rx, ry;
      rx = $urandom_range(0, 900);
      ry = $urandom_range(60, 900);
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          py[i] = ry + $urandom_range(40, 90);
          px[i] = rx + $urandom_range(0, 150) - 70;
        end else if (r == 1 && i > 0) begin
          py[i] = py[i-1];
          px[i] = rx + $urandom_range(0, 150) - 70;
        end else begin
          py[i] = $urandom_range(0, 2047) - 1024;
          px[i] = $urandom_range(0, 2047) - 1024;
        end
        act[i] = ($urandom_range(0, 3) != 0);
      end
      apply();
      scan(rx, ry, ($urandom_range(0, 3) != 0), 0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
